// File: rtl/yinger_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : yinger_pkg
//  Purpose  : Shared encodings for the Yinger MIPS multi-cycle controller:
//             opcodes, FSM state encoding and datapath mux/ALU selects.
//  Revision : 1.0  initial release
// ============================================================================
package yinger_pkg;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_lw    = 6'h23;
    localparam logic [5:0] c_op_sw    = 6'h2B;
    localparam logic [5:0] c_op_addi  = 6'h08;
    localparam logic [5:0] c_op_ori   = 6'h0D;
    localparam logic [5:0] c_op_beq   = 6'h04;
    localparam logic [5:0] c_op_j     = 6'h02;

    // Controller states
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_IF     = 4'd1,
        S_ID     = 4'd2,
        S_EX_R   = 4'd3,
        S_WB_R   = 4'd4,
        S_EX_I   = 4'd5,
        S_WB_I   = 4'd6,
        S_ADDR   = 4'd7,
        S_MEM_RD = 4'd8,
        S_WB_M   = 4'd9,
        S_MEM_WR = 4'd10,
        S_BR     = 4'd11,
        S_JMP    = 4'd12,
        S_TRAP   = 4'd13
    } state_t;

    // PC source select
    localparam logic [1:0] c_pc_seq  = 2'b00;
    localparam logic [1:0] c_pc_br   = 2'b01;
    localparam logic [1:0] c_pc_jmp  = 2'b10;

    // ALU operand B select
    localparam logic [1:0] c_alub_rt     = 2'b00;
    localparam logic [1:0] c_alub_four   = 2'b01;
    localparam logic [1:0] c_alub_imm    = 2'b10;
    localparam logic [1:0] c_alub_imm_sh = 2'b11;

    // ALU operation select
    localparam logic [1:0] c_aluop_add   = 2'b00;
    localparam logic [1:0] c_aluop_sub   = 2'b01;
    localparam logic [1:0] c_aluop_funct = 2'b10;
    localparam logic [1:0] c_aluop_or    = 2'b11;

    // Trap cause
    localparam logic [1:0] c_trap_none    = 2'b00;
    localparam logic [1:0] c_trap_illegal = 2'b01;
    localparam logic [1:0] c_trap_timeout = 2'b10;

endpackage
`default_nettype wire

// File: rtl/mc_ctrl_decode.sv
`default_nettype none
// ============================================================================
//  Module   : mc_ctrl_decode
//  Purpose  : Combinational primary-opcode classifier for the controller.
//  Revision : 1.0  initial release
// ============================================================================
module mc_ctrl_decode (
    input  logic [5:0] opcode,
    output logic       is_r,
    output logic       is_lw,
    output logic       is_sw,
    output logic       is_addi,
    output logic       is_ori,
    output logic       is_beq,
    output logic       is_j,
    output logic       illegal
);
    import yinger_pkg::*;

    // One-hot instruction class; anything unrecognised is flagged illegal
    always_comb begin
        is_r    = 1'b0;
        is_lw   = 1'b0;
        is_sw   = 1'b0;
        is_addi = 1'b0;
        is_ori  = 1'b0;
        is_beq  = 1'b0;
        is_j    = 1'b0;
        illegal = 1'b0;
        case (opcode)
            c_op_rtype: is_r    = 1'b1;
            c_op_lw:    is_lw   = 1'b1;
            c_op_sw:    is_sw   = 1'b1;
            c_op_addi:  is_addi = 1'b1;
            c_op_ori:   is_ori  = 1'b1;
            c_op_beq:   is_beq  = 1'b1;
            c_op_j:     is_j    = 1'b1;
            default:    illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mc_ctrl
//  Purpose  : Multi-cycle control FSM for the Yinger MIPS core. Sequences the
//             shared-memory datapath through fetch/decode/execute/memory/
//             writeback, handshakes with memory and traps on illegal opcodes
//             or memory timeouts.
//  Revision : 1.0  initial release
// ============================================================================
module mc_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       alu_zero,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       reg_we,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       retire,
    output logic       trap,
    output logic [1:0] trap_code
);
    import yinger_pkg::*;

    localparam int unsigned          c_cnt_w    = $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0]   c_cnt_last = c_cnt_w'(TIMEOUT - 1);

    state_t               state_q, state_d;
    logic [c_cnt_w-1:0]   cnt_q, cnt_d;
    logic [1:0]           code_q, code_d;

    logic w_is_r, w_is_lw, w_is_sw, w_is_addi, w_is_ori, w_is_beq, w_is_j, w_illegal;
    logic w_req_state;

    mc_ctrl_decode u_decode (
        .opcode  (opcode),
        .is_r    (w_is_r),
        .is_lw   (w_is_lw),
        .is_sw   (w_is_sw),
        .is_addi (w_is_addi),
        .is_ori  (w_is_ori),
        .is_beq  (w_is_beq),
        .is_j    (w_is_j),
        .illegal (w_illegal)
    );

    assign w_req_state = (state_q == S_IF) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);

    // Next-state, wait counter and trap cause. The counter defaults to zero so
    // any state change clears it; it only counts while a request sits unacked.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        code_d  = code_q;
        case (state_q)
            S_IDLE:   state_d = S_IF;
            S_IF:     if (mem_ack) state_d = S_ID;
            S_ID: begin
                if (w_illegal) begin
                    state_d = S_TRAP;
                    code_d  = c_trap_illegal;
                end else if (w_is_r)                 state_d = S_EX_R;
                else if (w_is_lw || w_is_sw)         state_d = S_ADDR;
                else if (w_is_addi || w_is_ori)      state_d = S_EX_I;
                else if (w_is_beq)                   state_d = S_BR;
                else if (w_is_j)                     state_d = S_JMP;
                else                                 state_d = S_TRAP;
            end
            S_EX_R:   state_d = S_WB_R;
            S_WB_R:   state_d = S_IF;
            S_EX_I:   state_d = S_WB_I;
            S_WB_I:   state_d = S_IF;
            S_ADDR:   state_d = w_is_lw ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: if (mem_ack) state_d = S_WB_M;
            S_WB_M:   state_d = S_IF;
            S_MEM_WR: if (mem_ack) state_d = S_IF;
            S_BR:     state_d = S_IF;
            S_JMP:    state_d = S_IF;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_IDLE;
        endcase
        // An ack on the final allowed cycle takes priority over the timeout
        if (w_req_state && !mem_ack) begin
            if (cnt_q == c_cnt_last) begin
                state_d = S_TRAP;
                code_d  = c_trap_timeout;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State, counter and trap-cause registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            code_q  <= c_trap_none;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
        end
    end

    // Datapath strobes decoded from state; IF, MEM_WR and BR also look at
    // ack/zero so the instruction can complete in the same cycle.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = c_pc_seq;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = c_alub_rt;
        alu_op     = c_aluop_add;
        retire     = 1'b0;
        trap       = 1'b0;
        trap_code  = c_trap_none;
        case (state_q)
            S_IF: begin
                mem_req   = 1'b1;
                alu_src_b = c_alub_four;
                ir_we     = mem_ack;
                pc_we     = mem_ack;
            end
            S_ID:     alu_src_b = c_alub_imm_sh;
            S_EX_R: begin
                alu_src_a = 1'b1;
                alu_op    = c_aluop_funct;
            end
            S_WB_R: begin
                reg_we  = 1'b1;
                reg_dst = 1'b1;
                retire  = 1'b1;
            end
            S_EX_I: begin
                alu_src_a = 1'b1;
                alu_src_b = c_alub_imm;
                alu_op    = w_is_ori ? c_aluop_or : c_aluop_add;
            end
            S_WB_I: begin
                reg_we = 1'b1;
                retire = 1'b1;
            end
            S_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = c_alub_imm;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_WB_M: begin
                reg_we     = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                retire  = mem_ack;
            end
            S_BR: begin
                alu_src_a = 1'b1;
                alu_op    = c_aluop_sub;
                pc_we     = alu_zero;
                pc_src    = c_pc_br;
                retire    = 1'b1;
            end
            S_JMP: begin
                pc_we  = 1'b1;
                pc_src = c_pc_jmp;
                retire = 1'b1;
            end
            S_TRAP: begin
                trap      = 1'b1;
                trap_code = code_q;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mc_ctrl
//  Purpose  : Self-checking bench for mc_ctrl (TIMEOUT = 4). Per-cycle input
//             vectors with expected output bundles, plus a hand sequence for
//             an asynchronous reset in the middle of a store.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic       alu_zero = 1'b0;
    logic       mem_ack = 1'b0;
    logic       mem_req, mem_we, iord, ir_we, pc_we, reg_we, reg_dst, mem_to_reg;
    logic       alu_src_a, retire, trap;
    logic [1:0] pc_src, alu_src_b, alu_op, trap_code;

    int checks = 0;
    int errors = 0;

    mc_ctrl #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .alu_zero   (alu_zero),
        .mem_ack    (mem_ack),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .pc_src     (pc_src),
        .reg_we     (reg_we),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .retire     (retire),
        .trap       (trap),
        .trap_code  (trap_code)
    );

    always #5 clk = ~clk;

    // Output bundle: req we iord irwe pcwe pcsrc[2] regwe regdst m2r srca srcb[2] op[2] retire trap code[2]
    function automatic logic [18:0] mk(input logic req, we, io, irw, pcw, input logic [1:0] pcs,
                                       input logic rw, rd, m2r, sa, input logic [1:0] sb, op,
                                       input logic ret, trp, input logic [1:0] tc);
        return {req, we, io, irw, pcw, pcs, rw, rd, m2r, sa, sb, op, ret, trp, tc};
    endfunction

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        zero;
        logic        ack;
        logic [18:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [18:0] sb_q[$];

    logic [18:0] E_ZERO, E_IF, E_IF_ACK, E_ID, E_EXR, E_WBR, E_EXI_ADD, E_EXI_OR, E_WBI;
    logic [18:0] E_ADDR, E_MRD, E_WBM, E_MWR, E_MWR_ACK, E_BR_T, E_BR_N, E_JMP, E_TRAP_ILL, E_TRAP_TO;

    function automatic logic [18:0] actual();
        return {mem_req, mem_we, iord, ir_we, pc_we, pc_src, reg_we, reg_dst, mem_to_reg,
                alu_src_a, alu_src_b, alu_op, retire, trap, trap_code};
    endfunction

    task automatic compare(input int id);
        logic [18:0] e;
        logic [18:0] a;
        e = sb_q.pop_front();
        a = actual();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL vec%0d outputs: got %05h expected %05h", id, a, e);
        end
        checks++;
        if (reg_we && mem_req) begin
            errors++;
            $display("FAIL vec%0d reg_we_and_mem_req: got 1 expected 0", id);
        end
    endtask

    task automatic apply(input logic r, input logic [5:0] o, input logic z, input logic a,
                         input logic [18:0] e, input int id);
        @(negedge clk);
        rst      = r;
        opcode   = o;
        alu_zero = z;
        mem_ack  = a;
        sb_q.push_back(e);
        #1;
        compare(id);
    endtask

    task automatic add(input logic r, input logic [5:0] o, input logic z, input logic a,
                       input logic [18:0] e);
        vec_t v;
        v.rst = r; v.op = o; v.zero = z; v.ack = a; v.exp = e;
        vecs.push_back(v);
    endtask

    initial begin
        E_ZERO     = '0;
        E_IF       = mk(1,0,0,0,0,2'b00,0,0,0,0,2'b01,2'b00,0,0,2'b00);
        E_IF_ACK   = mk(1,0,0,1,1,2'b00,0,0,0,0,2'b01,2'b00,0,0,2'b00);
        E_ID       = mk(0,0,0,0,0,2'b00,0,0,0,0,2'b11,2'b00,0,0,2'b00);
        E_EXR      = mk(0,0,0,0,0,2'b00,0,0,0,1,2'b00,2'b10,0,0,2'b00);
        E_WBR      = mk(0,0,0,0,0,2'b00,1,1,0,0,2'b00,2'b00,1,0,2'b00);
        E_EXI_ADD  = mk(0,0,0,0,0,2'b00,0,0,0,1,2'b10,2'b00,0,0,2'b00);
        E_EXI_OR   = mk(0,0,0,0,0,2'b00,0,0,0,1,2'b10,2'b11,0,0,2'b00);
        E_WBI      = mk(0,0,0,0,0,2'b00,1,0,0,0,2'b00,2'b00,1,0,2'b00);
        E_ADDR     = mk(0,0,0,0,0,2'b00,0,0,0,1,2'b10,2'b00,0,0,2'b00);
        E_MRD      = mk(1,0,1,0,0,2'b00,0,0,0,0,2'b00,2'b00,0,0,2'b00);
        E_WBM      = mk(0,0,0,0,0,2'b00,1,0,1,0,2'b00,2'b00,1,0,2'b00);
        E_MWR      = mk(1,1,1,0,0,2'b00,0,0,0,0,2'b00,2'b00,0,0,2'b00);
        E_MWR_ACK  = mk(1,1,1,0,0,2'b00,0,0,0,0,2'b00,2'b00,1,0,2'b00);
        E_BR_T     = mk(0,0,0,0,1,2'b01,0,0,0,1,2'b00,2'b01,1,0,2'b00);
        E_BR_N     = mk(0,0,0,0,0,2'b01,0,0,0,1,2'b00,2'b01,1,0,2'b00);
        E_JMP      = mk(0,0,0,0,1,2'b10,0,0,0,0,2'b00,2'b00,1,0,2'b00);
        E_TRAP_ILL = mk(0,0,0,0,0,2'b00,0,0,0,0,2'b00,2'b00,0,1,2'b01);
        E_TRAP_TO  = mk(0,0,0,0,0,2'b00,0,0,0,0,2'b00,2'b00,0,1,2'b10);

        // Reset, then R-type with zero wait
        add(0, 6'h00, 0, 0, E_ZERO);
        add(0, 6'h00, 0, 0, E_ZERO);
        add(1, 6'h00, 0, 0, E_ZERO);
        add(1, 6'h00, 0, 1, E_IF_ACK);
        add(1, 6'h00, 0, 1, E_ID);
        add(1, 6'h00, 0, 1, E_EXR);
        add(1, 6'h00, 0, 1, E_WBR);
        // lw with two wait cycles in MEM_RD
        add(1, 6'h23, 0, 1, E_IF_ACK);
        add(1, 6'h23, 0, 1, E_ID);
        add(1, 6'h23, 0, 1, E_ADDR);
        add(1, 6'h23, 0, 0, E_MRD);
        add(1, 6'h23, 0, 0, E_MRD);
        add(1, 6'h23, 0, 1, E_MRD);
        add(1, 6'h23, 0, 1, E_WBM);
        // beq taken, then not taken
        add(1, 6'h04, 1, 1, E_IF_ACK);
        add(1, 6'h04, 1, 1, E_ID);
        add(1, 6'h04, 1, 1, E_BR_T);
        add(1, 6'h04, 0, 1, E_IF_ACK);
        add(1, 6'h04, 0, 1, E_ID);
        add(1, 6'h04, 0, 1, E_BR_N);
        // sw, addi, ori, j
        add(1, 6'h2B, 0, 1, E_IF_ACK);
        add(1, 6'h2B, 0, 1, E_ID);
        add(1, 6'h2B, 0, 1, E_ADDR);
        add(1, 6'h2B, 0, 1, E_MWR_ACK);
        add(1, 6'h08, 0, 1, E_IF_ACK);
        add(1, 6'h08, 0, 1, E_ID);
        add(1, 6'h08, 0, 1, E_EXI_ADD);
        add(1, 6'h08, 0, 1, E_WBI);
        add(1, 6'h0D, 0, 1, E_IF_ACK);
        add(1, 6'h0D, 0, 1, E_ID);
        add(1, 6'h0D, 0, 1, E_EXI_OR);
        add(1, 6'h0D, 0, 1, E_WBI);
        add(1, 6'h02, 0, 1, E_IF_ACK);
        add(1, 6'h02, 0, 1, E_ID);
        add(1, 6'h02, 0, 1, E_JMP);
        // Ack on the last allowed fetch cycle wins over the timeout
        add(1, 6'h00, 0, 0, E_IF);
        add(1, 6'h00, 0, 0, E_IF);
        add(1, 6'h00, 0, 0, E_IF);
        add(1, 6'h00, 0, 1, E_IF_ACK);
        add(1, 6'h00, 0, 1, E_ID);
        add(1, 6'h00, 0, 1, E_EXR);
        add(1, 6'h00, 0, 1, E_WBR);
        // Fetch never acked: trap after four request cycles
        add(1, 6'h00, 0, 0, E_IF);
        add(1, 6'h00, 0, 0, E_IF);
        add(1, 6'h00, 0, 0, E_IF);
        add(1, 6'h00, 0, 0, E_IF);
        add(1, 6'h00, 0, 0, E_TRAP_TO);
        add(1, 6'h00, 0, 1, E_TRAP_TO);
        add(0, 6'h00, 0, 0, E_ZERO);
        // Illegal opcode
        add(1, 6'h3F, 0, 0, E_ZERO);
        add(1, 6'h3F, 0, 1, E_IF_ACK);
        add(1, 6'h3F, 0, 1, E_ID);
        add(1, 6'h3F, 0, 1, E_TRAP_ILL);
        add(1, 6'h3F, 0, 1, E_TRAP_ILL);
        add(0, 6'h00, 0, 0, E_ZERO);
        add(1, 6'h00, 0, 0, E_ZERO);
        add(1, 6'h00, 0, 0, E_IF);

        #1 rst = 1'b0;

        foreach (vecs[i])
            apply(vecs[i].rst, vecs[i].op, vecs[i].zero, vecs[i].ack, vecs[i].exp, i);

        // Asynchronous reset while a store is waiting for its ack
        apply(1, 6'h2B, 0, 1, E_IF_ACK, 100);
        apply(1, 6'h2B, 0, 0, E_ID,     101);
        apply(1, 6'h2B, 0, 0, E_ADDR,   102);
        apply(1, 6'h2B, 0, 0, E_MWR,    103);
        #2;
        rst = 1'b0;
        sb_q.push_back(E_ZERO);
        #1;
        compare(104);
        apply(0, 6'h2B, 0, 0, E_ZERO, 105);
        apply(1, 6'h2B, 0, 0, E_ZERO, 106);
        apply(1, 6'h2B, 0, 0, E_IF,   107);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
